// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared types and default constants for the switch_debounce block.
//   db_state_t          : debounce FSM state encoding
//   DB_SYNC_STAGES_DEF  : default synchroniser depth
//   DB_CYCLES_DEF       : default stable-cycle requirement
//   DB_CNT_W_DEF        : default hold-counter width
//   GLITCH_MAX          : saturation value of the rejected-bounce counter
// -----------------------------------------------------------------------------
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_LO   = 2'd0,
    WAIT_HI = 2'd1,
    ST_HI   = 2'd2,
    WAIT_LO = 2'd3
  } db_state_t;

  localparam int DB_SYNC_STAGES_DEF = 2;
  localparam int DB_CYCLES_DEF      = 1000;
  localparam int DB_CNT_W_DEF       = 10;

  localparam logic [7:0] GLITCH_MAX = 8'hFF;

endpackage

// File: rtl/bit_sync.sv
// -----------------------------------------------------------------------------
// bit_sync
// Multi-flop synchroniser bringing one asynchronous bit into the clk domain.
// Ports:
//   clk   : destination clock
//   reset : asynchronous active-high reset, clears every stage to 0
//   d     : asynchronous input bit
//   q     : synchronised output (last stage of the chain)
// Parameter SYNC_STAGES (>= 2) sets the chain length.
// -----------------------------------------------------------------------------
module bit_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/switch_debounce.sv
// -----------------------------------------------------------------------------
// switch_debounce
// Conditions a raw asynchronous single-bit input: synchronises it, rejects
// bounces shorter than DEBOUNCE_CYCLES stable cycles, and produces a clean
// registered level plus one-cycle rise/fall pulses.
// Ports:
//   clk        : single clock, all state on posedge
//   reset      : asynchronous active-high reset, clears all state
//   din        : raw input, asynchronous to clk
//   q          : debounced level (registered)
//   rise       : one-cycle pulse when q goes 0->1
//   fall       : one-cycle pulse when q goes 1->0
//   glitch_cnt : saturating count of rejected bounces (only when the macro
//                DEBOUNCE_STATS_EN is defined)
// Handshake: none; q/rise/fall are free-running registered outputs, a pulse
// is valid for exactly the single cycle it is high.
// The FSM state is held in the db_state_t register 'state'.
// -----------------------------------------------------------------------------
module switch_debounce
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DB_SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W           = DB_CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  output logic       q,
  output logic       rise,
  output logic       fall
`ifdef DEBOUNCE_STATS_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic              s;
  db_state_t         state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              q_n, rise_n, fall_n;

  bit_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (din),
    .q    (s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_LO;
      cnt   <= '0;
      q     <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      q     <= q_n;
      rise  <= rise_n;
      fall  <= fall_n;
    end
  end

  // Acceptance happens when cnt reaches DEBOUNCE_CYCLES-1, so cnt never
  // needs to count past its last value and cannot wrap.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    q_n     = q;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    case (state)
      ST_LO: begin
        if (s) begin
          state_n = WAIT_HI;
          cnt_n   = '0;
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_n = ST_LO;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = ST_HI;
          q_n     = 1'b1;
          rise_n  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      ST_HI: begin
        if (!s) begin
          state_n = WAIT_LO;
          cnt_n   = '0;
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_n = ST_HI;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = ST_LO;
          q_n     = 1'b0;
          fall_n  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: begin
        state_n = ST_LO;
        cnt_n   = '0;
      end
    endcase
  end

`ifdef DEBOUNCE_STATS_EN
  // A rejected bounce is any WAIT state falling back to its stable state.
  logic glitch;
  assign glitch = ((state == WAIT_HI) && !s) || ((state == WAIT_LO) && s);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      glitch_cnt <= 8'h00;
    end else if (glitch && (glitch_cnt != GLITCH_MAX)) begin
      glitch_cnt <= glitch_cnt + 8'h01;
    end
  end
`else
  // Statistics disabled: no rejected-bounce counter.
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// -----------------------------------------------------------------------------
// tb_switch_debounce
// Directed bench for switch_debounce with SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// 20 ns clock. The driver pushes each expected pulse (kind + cycle) into
// exp_q; a monitor pops and compares whenever rise or fall is high. Level
// and counter values are compared directly at fixed points.
// A change of din driven at a negedge is sampled at the next posedge; q and
// the pulse change 6 posedges after that, i.e. 7 posedges after the drive.
// -----------------------------------------------------------------------------
module tb_switch_debounce;

  localparam int LAT = 7;

  logic clk = 1'b0;
  logic reset;
  logic din;
  logic q, rise, fall;
`ifdef DEBOUNCE_STATS_EN
  logic [7:0] glitch_cnt;
`endif

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  // {is_fall, cycle[15:0]}
  logic [16:0] exp_q[$];
  logic [16:0] mon_exp, mon_got;

  switch_debounce #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .q         (q),
    .rise      (rise),
    .fall      (fall)
`ifdef DEBOUNCE_STATS_EN
    ,
    .glitch_cnt(glitch_cnt)
`endif
  );

  // clock / cycle counter
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // driver helpers
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pulse(input logic is_fall, input int at);
    exp_q.push_back({is_fall, 16'(at)});
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rise || fall) begin
      checks++;
      if (rise && fall) begin
        failures++;
        $display("FAIL pulse_both cycle=%0d actual=rise+fall expected=one", cyc);
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pulse_unexpected cycle=%0d fall=%0b expected=none", cyc, fall);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_got = {fall, 16'(cyc)};
        if (mon_got !== mon_exp) begin
          failures++;
          $display("FAIL pulse actual fall=%0b cycle=%0d expected fall=%0b cycle=%0d",
                   mon_got[16], mon_got[15:0], mon_exp[16], mon_exp[15:0]);
        end
      end
    end
  end

  initial begin
    // reset with din high
    reset = 1'b1;
    din   = 1'b1;
    step(3);
    check("reset_q", q, 0);
    check("reset_rise", rise, 0);
    check("reset_fall", fall, 0);
`ifdef DEBOUNCE_STATS_EN
    check("reset_glitch", glitch_cnt, 0);
`endif
    reset = 1'b0;
    expect_pulse(1'b0, cyc + LAT);
    step(10);
    check("post_reset_q", q, 1);

    // asynchronous reset clears q without a clock edge
    #3 reset = 1'b1;
    #1 check("async_reset_q", q, 0);
    din = 1'b0;
    step(2);
    reset = 1'b0;
    step(3);
    check("idle_q", q, 0);

    // clean press / release
    din = 1'b1;
    expect_pulse(1'b0, cyc + LAT);
    step(10);
    check("press_q", q, 1);
    din = 1'b0;
    expect_pulse(1'b1, cyc + LAT);
    step(10);
    check("release_q", q, 0);

    // bounce rejection: 2 high, 1 low, 3 high, low
    din = 1'b1; step(2);
    din = 1'b0; step(1);
    din = 1'b1; step(3);
    din = 1'b0; step(10);
    check("bounce_q", q, 0);
`ifdef DEBOUNCE_STATS_EN
    check("bounce_glitch", glitch_cnt, 2);
`endif

    // bounce then settle high
    din = 1'b1; step(1);
    din = 1'b0; step(1);
    din = 1'b1;
    expect_pulse(1'b0, cyc + LAT);
    step(12);
    check("settle_q", q, 1);
`ifdef DEBOUNCE_STATS_EN
    check("settle_glitch", glitch_cnt, 3);
`endif
    din = 1'b0;
    expect_pulse(1'b1, cyc + LAT);
    step(10);
    check("settle_release_q", q, 0);

    // reset two cycles into WAIT_HI, held one cycle
    din = 1'b1;
    step(4);
    reset = 1'b1;
    #1 check("midwait_reset_q", q, 0);
    step(1);
    reset = 1'b0;
    expect_pulse(1'b0, cyc + LAT);
    step(6);
    check("midwait_early_q", q, 0);
    step(4);
    check("midwait_q", q, 1);
`ifdef DEBOUNCE_STATS_EN
    check("midwait_glitch", glitch_cnt, 0);
`endif
    din = 1'b0;
    expect_pulse(1'b1, cyc + LAT);
    step(10);
    check("midwait_release_q", q, 0);

    // 300 one-cycle glitches
    repeat (300) begin
      din = 1'b1; step(1);
      din = 1'b0; step(1);
    end
    step(5);
    check("sat_q", q, 0);
`ifdef DEBOUNCE_STATS_EN
    check("sat_glitch", glitch_cnt, 255);
`endif

    // every expected pulse must have been seen
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pulses_missing actual=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
